ecap5_dwbmem_bram_pipe: RTL and testbench

ECAP5_DWBMEM_BRAM_PIPE -- requirements
Module: ecap5_dwbmem_bram_pipe

---
 rtl/ecap5_dwbmem_bram_pipe.sv | 147 ++++++++++++++
 tb/tb_ecap5_dwbmem_bram_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecap5_dwbmem_bram_pipe.sv
// rtl/ecap5_dwbmem_bram_pipe.sv - Wishbone B4 pipelined single-port BRAM slave with optional clear-on-reset
`timescale 1ns/1ps
module ecap5_dwbmem_bram_pipe #(
    parameter int          DEPTH          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          OUT_REG        = 0,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic          w_clearing;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clearing    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clearing    = ~rst_i;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_READY;
                end
            end
            default: ;
        endcase
    end

    assign wb_stall_o = rst_i | (r_state == S_CLEAR);

    // BASE_ADDR is aligned to the memory size, so the offset's upper bits are zero exactly when in range
    logic          w_accept;
    logic [31:0]   w_offset;
    logic          w_valid;
    logic [AW-1:0] w_idx;

    assign w_accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign w_offset = wb_adr_i - BASE_ADDR;
    assign w_valid  = (w_offset[1:0] == 2'b00) && (w_offset[31:AW+2] == '0);
    assign w_idx    = w_offset[AW+1:2];

    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;
    logic [3:0]    w_mem_be;

    always_comb begin
        w_mem_addr  = w_idx;
        w_mem_wdata = wb_dat_i;
        w_mem_be    = (w_accept & w_valid & wb_we_i) ? wb_sel_i : 4'b0000;
        if (w_clearing) begin
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = '0;
            w_mem_be    = 4'hF;
        end
    end

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_be[b]) begin
                r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[w_mem_addr];
    end

    logic        r_v1;
    logic        r_err1;
    logic        r_rd1;
    logic [31:0] w_dat1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1   <= 1'b0;
            r_err1 <= 1'b0;
            r_rd1  <= 1'b0;
        end else begin
            r_v1   <= w_accept;
            r_err1 <= w_accept & ~w_valid;
            r_rd1  <= w_accept & w_valid & ~wb_we_i;
        end
    end

    assign w_dat1 = r_rd1 ? r_rdata : '0;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic        r_v2;
            logic        r_err2;
            logic [31:0] r_dat2;

            // A cycle with wb_cyc_i low kills whatever is still travelling to the output
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_v2   <= 1'b0;
                    r_err2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_v2   <= r_v1 & wb_cyc_i;
                    r_err2 <= r_err1;
                    r_dat2 <= wb_cyc_i ? w_dat1 : '0;
                end
            end

            assign wb_ack_o = r_v2 & ~r_err2;
            assign wb_err_o = r_v2 & r_err2;
            assign wb_dat_o = r_dat2;
        end else begin : g_direct
            assign wb_ack_o = r_v1 & ~r_err1;
            assign wb_err_o = r_v1 & r_err1;
            assign wb_dat_o = w_dat1;
        end
    endgenerate

endmodule

// File: tb/tb_ecap5_dwbmem_bram_pipe.sv
// tb/tb_ecap5_dwbmem_bram_pipe.sv - self-checking bench for ecap5_dwbmem_bram_pipe
`timescale 1ns/1ps
module tb_ecap5_dwbmem_bram_pipe;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [31:0] dat_o   [3];
    logic        ack_o   [3];
    logic        err_o   [3];
    logic        stall_o [3];

    ecap5_dwbmem_bram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[0]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]), .wb_stall_o(stall_o[0]));

    ecap5_dwbmem_bram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[1]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]), .wb_stall_o(stall_o[1]));

    ecap5_dwbmem_bram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[2]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack_o[2]), .wb_err_o(err_o[2]), .wb_stall_o(stall_o[2]));

    // Reference model: per-instance word array, clear countdown and termination events stamped with their due edge
    typedef struct {
        bit          v;
        bit          err;
        logic [31:0] dat;
        int          due;
    } ev_t;

    int          lat    [3] = '{1, 2, 1};
    bit          clr_en [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] mem    [3][DEPTH];
    int          clr_left [3] = '{0, 0, 0};
    ev_t         ev     [3][4];
    int          n_edge = 0;
    int          total  = 0;
    int          bad    = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, d, obs, expv);
        end
    endtask

    task automatic model_edge();
        n_edge++;
        for (int d = 0; d < 3; d++) begin
            bit          stall_now;
            bit          ok;
            int          idx;
            int          slot;
            logic [31:0] off;
            stall_now = rst || (clr_left[d] > 0);
            if (rst || !cyc) begin
                for (int k = 0; k < 4; k++) ev[d][k].v = 1'b0;
            end
            if (!stall_now && cyc && stb) begin
                off  = adr - BASE;
                ok   = (adr[1:0] == 2'b00) && (adr >= BASE) && (adr < BASE + 32'(4 * DEPTH));
                idx  = int'(off >> 2);
                slot = (n_edge + lat[d] - 1) & 3;
                ev[d][slot].v   = 1'b1;
                ev[d][slot].err = !ok;
                ev[d][slot].due = n_edge + lat[d] - 1;
                ev[d][slot].dat = 32'h0;
                if (ok && we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) mem[d][idx][8*b +: 8] = wdat[8*b +: 8];
                    end
                end
                if (ok && !we) ev[d][slot].dat = mem[d][idx];
            end
            if (rst) begin
                clr_left[d] = clr_en[d] ? DEPTH : 0;
                if (clr_en[d]) begin
                    for (int w = 0; w < DEPTH; w++) mem[d][w] = 32'h0;
                end
            end else if (clr_left[d] > 0) begin
                clr_left[d]--;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 3; d++) begin
            int          slot;
            logic        e_ack;
            logic        e_err;
            logic [31:0] e_dat;
            slot  = n_edge & 3;
            e_ack = 1'b0;
            e_err = 1'b0;
            e_dat = 32'h0;
            if (ev[d][slot].v && ev[d][slot].due == n_edge) begin
                e_ack = !ev[d][slot].err;
                e_err = ev[d][slot].err;
                e_dat = ev[d][slot].dat;
                ev[d][slot].v = 1'b0;
            end
            chk("ack", d, 32'(ack_o[d]), 32'(e_ack));
            chk("err", d, 32'(err_o[d]), 32'(e_err));
            chk("stall", d, 32'(stall_o[d]), 32'(rst || (clr_left[d] > 0)));
            if (!$isunknown(e_dat)) chk("dat", d, dat_o[d], e_dat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        tick();
    endtask

    task automatic idle();
        stb = 1'b0;
        we  = 1'b0;
        tick();
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        cnt = 0;
        #1;
        if (stall_o[0]) cnt++;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (stall_o[0]) cnt++;
            else break;
        end
        chk(tag, 0, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        rst  = 1'b1;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        adr  = 32'h0;
        wdat = 32'h0;
        sel  = 4'h0;

        tick();
        tick();
        rst = 1'b0;
        count_clear("clear_len");

        req(1'b0, 32'h1000_03FC, 32'h0, 4'hF);
        chk("last_word_ack", 0, 32'(ack_o[0]), 32'h1);
        chk("last_word_dat", 0, dat_o[0], 32'h0);
        idle();

        req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("wr1_ack", 0, 32'(ack_o[0]), 32'h1);
        req(1'b1, 32'h1000_0004, 32'h0000_AA00, 4'h2);
        req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        chk("byte_merge", 0, dat_o[0], 32'hDEAD_AAEF);
        idle();
        chk("byte_merge_oreg", 1, dat_o[1], 32'hDEAD_AAEF);
        idle();

        req(1'b1, 32'h1000_0000, 32'h1, 4'hF);
        req(1'b1, 32'h1000_0004, 32'h2, 4'hF);
        req(1'b1, 32'h1000_0008, 32'h3, 4'hF);
        idle();
        idle();
        req(1'b0, 32'h1000_0000, 32'h0, 4'hF);
        chk("oreg_lat_t1", 1, 32'(ack_o[1]), 32'h0);
        req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        chk("oreg_rd0", 1, dat_o[1], 32'h1);
        req(1'b0, 32'h1000_0008, 32'h0, 4'hF);
        chk("oreg_rd1", 1, dat_o[1], 32'h2);
        idle();
        chk("oreg_rd2", 1, dat_o[1], 32'h3);
        idle();

        req(1'b1, 32'h1000_0400, 32'hFFFF_FFFF, 4'hF);
        chk("range_err", 0, 32'(err_o[0]), 32'h1);
        req(1'b1, 32'h1000_0002, 32'hFFFF_FFFF, 4'hF);
        chk("align_err", 0, 32'(err_o[0]), 32'h1);
        chk("range_err_oreg", 1, 32'(err_o[1]), 32'h1);
        req(1'b0, 32'h1000_0000, 32'h0, 4'hF);
        chk("err_no_write", 0, dat_o[0], 32'h1);
        idle();
        idle();

        req(1'b1, 32'h1000_0008, 32'h55, 4'hF);
        cyc = 1'b0;
        stb = 1'b0;
        tick();
        chk("flush_ack", 1, 32'(ack_o[1]), 32'h0);
        chk("flush_err", 1, 32'(err_o[1]), 32'h0);
        tick();
        req(1'b0, 32'h1000_0008, 32'h0, 4'hF);
        idle();
        chk("flush_kept_write", 1, dat_o[1], 32'h55);

        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r    = $urandom_range(0, 7);
            cyc  = ($urandom_range(0, 9) != 0);
            stb  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            sel  = 4'($urandom);
            wdat = $urandom;
            case (r)
                0, 1, 2, 3, 4: adr = BASE + 32'(4 * $urandom_range(0, 7));
                5:             adr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                6:             adr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                default:       adr = ($urandom_range(0, 1) != 0) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                                 : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 4));
            endcase
            tick();
        end
        cyc = 1'b1;
        idle();
        idle();

        req(1'b1, 32'h1000_00F0, 32'hCAFE_F00D, 4'hF);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        chk("stall_in_rst", 0, 32'(stall_o[0]), 32'h1);
        rst = 1'b0;
        count_clear("clear_restart_len");
        req(1'b0, 32'h1000_00F0, 32'h0, 4'hF);
        chk("cleared_word", 0, dat_o[0], 32'h0);
        chk("kept_word_noclear", 2, dat_o[2], 32'hCAFE_F00D);
        idle();
        chk("cleared_word_oreg", 1, dat_o[1], 32'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
